// File: rtl/hex_display_ctrl.sv
// Multi-digit active-low seven-segment controller: value register loaded by
// valid/ready, HEX / leading-zero-blank / blink / free-running count modes.
module hex_display_ctrl #(
  parameter int DIGITS  = 6,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [1:0]            mode,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_HEX   = 2'b00,
    MODE_LZB   = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_COUNT = 2'b11
  } mode_t;

  logic [4*DIGITS-1:0] value_q;
  logic [4*DIGITS-1:0] value_next;
  mode_t               mode_q;
  logic [DIGITS-1:0]   mask_q;
  logic                phase_q;
  logic [PW-1:0]       presc_q;
  logic                tick_int;
  logic                accept;
  logic [7*DIGITS-1:0] hex_next;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign tick_int = (presc_q == LAST);
  assign accept   = load_valid && load_ready;

  // A coinciding load takes priority over the COUNT increment.
  always_comb begin
    value_next = value_q;
    if (accept)
      value_next = load_value;
    else if (mode_q == MODE_COUNT && tick_int)
      value_next = value_q + (4*DIGITS)'(1);
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic upper_zero;
    logic blank;
    assign upper_zero = (value_q[4*DIGITS-1:4*gi] == '0);
    always_comb begin
      blank = 1'b0;
      case (mode_q)
        MODE_LZB:   blank = (gi > 0) && upper_zero;
        MODE_BLINK: blank = mask_q[gi] && phase_q;
        default:    blank = 1'b0;
      endcase
    end
    assign hex_next[7*gi +: 7] = blank ? 7'h7F : glyph(value_q[4*gi +: 4]);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      value_q    <= '0;
      mode_q     <= MODE_HEX;
      mask_q     <= '0;
      phase_q    <= 1'b0;
      presc_q    <= '0;
      tick       <= 1'b0;
      load_ready <= 1'b0;
      HEX        <= '1;
    end else begin
      value_q    <= value_next;
      mode_q     <= mode_t'(mode);
      mask_q     <= blink_mask;
      presc_q    <= tick_int ? '0 : presc_q + PW'(1);
      phase_q    <= phase_q ^ tick_int;
      tick       <= tick_int;
      load_ready <= 1'b1;
      HEX        <= hex_next;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed + randomized bench for hex_display_ctrl (DIGITS=2, DIV=4) against a
// behavioural model derived from edge counts and arithmetic on the held value.
module tb_hex_display_ctrl;

  localparam int DIGITS = 2;
  localparam int DIV    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_value;
  logic [1:0]  mode;
  logic [1:0]  blink_mask;
  logic [13:0] HEX;
  logic        tick;

  int checks = 0;
  int errors = 0;

  logic [6:0] GLY [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model state: edges since reset release, plus the held value/mode/mask.
  int         n;
  logic [7:0] m_value;
  logic [1:0] m_mode;
  logic [1:0] m_mask;
  bit         m_ready;

  always #5 clk = ~clk;

  hex_display_ctrl #(.DIGITS(DIGITS), .CLK_HZ(8), .TICK_HZ(2)) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .mode       (mode),
    .blink_mask (blink_mask),
    .HEX        (HEX),
    .tick       (tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] render(input logic [7:0] v, input logic [1:0] md,
                                         input logic [1:0] mk, input bit ph);
    logic [13:0] r;
    logic [6:0]  g;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      g = GLY[(v >> (4*i)) & 8'hF];
      if (md == 2'b01 && i > 0 && (v >> (4*i)) == 0) g = 7'h7F;
      if (md == 2'b10 && mk[i] && ph) g = 7'h7F;
      r[7*i +: 7] = g;
    end
    return r;
  endfunction

  task automatic model_reset();
    n       = 0;
    m_value = 8'h00;
    m_mode  = 2'b00;
    m_mask  = 2'b00;
    m_ready = 1'b0;
  endtask

  task automatic step();
    logic [13:0] eh;
    bit          et;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      #1;
      check("rst_hex", HEX, 14'h3FFF);
      check("rst_ready", load_ready, 0);
      check("rst_tick", tick, 0);
    end else begin
      eh = render(m_value, m_mode, m_mask, ((n / DIV) % 2) == 1);
      n++;
      et = (n % DIV) == 0;
      if (load_valid && m_ready)
        m_value = load_value;
      else if (m_mode == 2'b11 && et)
        m_value = m_value + 8'd1;
      m_mode  = mode;
      m_mask  = blink_mask;
      m_ready = 1'b1;
      #1;
      check("hex", HEX, eh);
      check("tick", tick, et);
      check("ready", load_ready, 1);
    end
  endtask

  task automatic load(input logic [7:0] v);
    load_valid = 1'b1;
    load_value = v;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    int pulses;
    int last;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_value = 8'h00;
    mode       = 2'b00;
    blink_mask = 2'b00;
    model_reset();

    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    step();
    check("first_edge_hex", HEX, 14'h2040);
    check("first_edge_ready", load_ready, 1);

    // HEX mode: A7 then every nibble on both digits.
    load(8'hA7);
    step();
    check("hex_a7", HEX, {7'b0001000, 7'b1111000});
    for (int k = 0; k < 16; k++) begin
      load({4'(k), 4'(15 - k)});
      step();
      check("hex_nibbles", HEX, {GLY[k], GLY[15 - k]});
    end

    // Leading-zero blanking.
    mode = 2'b01;
    step();
    load(8'h05); step();
    check("lzb_05", HEX, {7'h7F, GLY[5]});
    load(8'h00); step();
    check("lzb_00", HEX, {7'h7F, GLY[0]});
    load(8'h50); step();
    check("lzb_50", HEX, {GLY[5], GLY[0]});

    // Blink digit 1 only; digit 0 must hold "C".
    mode       = 2'b10;
    blink_mask = 2'b10;
    load(8'h3C);
    step();
    for (int k = 0; k < 16; k++) begin
      step();
      check("blink_digit0", HEX[6:0], GLY[12]);
    end

    // COUNT: wrap through FF->00, then a load colliding with a tick.
    mode       = 2'b11;
    blink_mask = 2'b00;
    step();
    load(8'hFE);
    for (int k = 0; k < 12; k++) step();
    for (int k = 0; k < DIV && ((n + 1) % DIV) != 0; k++) step();
    load(8'h40);
    step();
    check("count_collision", HEX, {GLY[4], GLY[0]});
    for (int k = 0; k < 4; k++) step();
    check("count_after", HEX, {GLY[4], GLY[1]});

    // Tick spacing with mode changes between pulses.
    pulses = 0;
    last   = -1;
    for (int k = 0; k < 40; k++) begin
      mode = 2'($urandom_range(0, 3));
      step();
      if (tick) begin
        if (last >= 0) check("tick_gap", k - last, DIV);
        last = k;
        pulses++;
      end
    end
    check("tick_pulses", pulses, 10);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      load_valid = 1'($urandom_range(0, 1));
      load_value = 8'($urandom);
      mode       = 2'($urandom_range(0, 3));
      blink_mask = 2'($urandom_range(0, 3));
      step();
    end

    // Asynchronous reset mid-cycle with a pending load.
    load_valid = 1'b1;
    load_value = 8'h99;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_hex", HEX, 14'h3FFF);
    check("async_rst_ready", load_ready, 0);
    check("async_rst_tick", tick, 0);
    step();
    #2;
    rst_n = 1'b1;
    step();
    check("rerelease_hex", HEX, 14'h2040);
    load_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
